// File: rtl/fifo_pkg.sv
// Shared constants for the pushbutton FIFO demo: geometry and 7-segment encoding.
package fifo_pkg;

  localparam int unsigned DATA_W = 15;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned PTR_W  = 4;
  localparam int unsigned ADDR_W = PTR_W - 1;

  // Active-low segments, bit order {g,f,e,d,c,b,a}; all segments off.
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg7_encode(input logic [3:0] nib);
    return SEG7_TABLE[nib];
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_seg7
  import fifo_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  // Table lookup of the segment pattern for the nibble.
  always_comb begin
    o_seg = seg7_encode(i_hex);
  end

endmodule

// File: rtl/button_fifo.sv
// 8 x 15-bit FIFO operated one word per pushbutton press; head word shown on four
// 7-segment digits, full/empty flags exported.
module button_fifo
  import fifo_pkg::*;
(
  input  logic              clock,
  input  logic              resetN,
  input  logic              button,
  input  logic              wren,
  input  logic [DATA_W-1:0] dataIn,
  output logic [6:0]        dataHex0,
  output logic [6:0]        dataHex1,
  output logic [6:0]        dataHex2,
  output logic [6:0]        dataHex3,
  output logic              full,
  output logic              empty
);

  logic              r_btnMeta;
  logic              r_btnSync;
  logic              r_btnPrev;
  logic              w_press;
  logic              w_doWrite;
  logic              w_doRead;
  logic [PTR_W-1:0]  r_wrAdd;
  logic [PTR_W-1:0]  r_rdAdd;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] w_head;
  logic [6:0]        w_seg0;
  logic [6:0]        w_seg1;
  logic [6:0]        w_seg2;
  logic [6:0]        w_seg3;

  // Synchronize the asynchronous button and keep its previous synchronized value.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_btnMeta <= 1'b1;
      r_btnSync <= 1'b1;
      r_btnPrev <= 1'b1;
    end else begin
      r_btnMeta <= button;
      r_btnSync <= r_btnMeta;
      r_btnPrev <= r_btnSync;
    end
  end

  // One-cycle pulse on the released-to-pressed transition; qualify by flags.
  always_comb begin
    w_press   = r_btnPrev & ~r_btnSync;
    w_doWrite = w_press & wren & ~full;
    w_doRead  = w_press & ~wren & ~empty;
  end

  // Pointer update; the MSB acts as the wrap bit distinguishing full from empty.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_wrAdd <= '0;
      r_rdAdd <= '0;
    end else begin
      if (w_doWrite) r_wrAdd <= r_wrAdd + 1'b1;
      if (w_doRead)  r_rdAdd <= r_rdAdd + 1'b1;
    end
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clock) begin
    if (w_doWrite) r_mem[r_wrAdd[ADDR_W-1:0]] <= dataIn;
  end

  // Flags derived from the registered pointers; head word read asynchronously.
  always_comb begin
    empty  = (r_wrAdd == r_rdAdd);
    full   = (r_wrAdd[PTR_W-1] != r_rdAdd[PTR_W-1]) &&
             (r_wrAdd[ADDR_W-1:0] == r_rdAdd[ADDR_W-1:0]);
    w_head = r_mem[r_rdAdd[ADDR_W-1:0]];
  end

  hex_to_seg7 u_hex0 (.i_hex(w_head[3:0]),           .o_seg(w_seg0));
  hex_to_seg7 u_hex1 (.i_hex(w_head[7:4]),           .o_seg(w_seg1));
  hex_to_seg7 u_hex2 (.i_hex(w_head[11:8]),          .o_seg(w_seg2));
  hex_to_seg7 u_hex3 (.i_hex({1'b0, w_head[14:12]}), .o_seg(w_seg3));

  // Blank every digit while there is nothing to show.
  always_comb begin
    dataHex0 = empty ? SEG_BLANK : w_seg0;
    dataHex1 = empty ? SEG_BLANK : w_seg1;
    dataHex2 = empty ? SEG_BLANK : w_seg2;
    dataHex3 = empty ? SEG_BLANK : w_seg3;
  end

endmodule

// File: tb/tb_button_fifo.sv
// Directed self-checking bench for button_fifo.
module tb_button_fifo;

  logic        clock;
  logic        resetN;
  logic        button;
  logic        wren;
  logic [14:0] dataIn;
  logic [6:0]  dataHex0;
  logic [6:0]  dataHex1;
  logic [6:0]  dataHex2;
  logic [6:0]  dataHex3;
  logic        full;
  logic        empty;

  int checks   = 0;
  int failures = 0;

  button_fifo dut (
    .clock    (clock),
    .resetN   (resetN),
    .button   (button),
    .wren     (wren),
    .dataIn   (dataIn),
    .dataHex0 (dataHex0),
    .dataHex1 (dataHex1),
    .dataHex2 (dataHex2),
    .dataHex3 (dataHex3),
    .full     (full),
    .empty    (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_digits(input string tag, input logic [6:0] h3, input logic [6:0] h2,
                              input logic [6:0] h1, input logic [6:0] h0);
    check({tag, ".hex3"}, {9'd0, dataHex3}, {9'd0, h3});
    check({tag, ".hex2"}, {9'd0, dataHex2}, {9'd0, h2});
    check({tag, ".hex1"}, {9'd0, dataHex1}, {9'd0, h1});
    check({tag, ".hex0"}, {9'd0, dataHex0}, {9'd0, h0});
  endtask

  task automatic check_flags(input string tag, input logic e, input logic f);
    check({tag, ".empty"}, {15'd0, empty}, {15'd0, e});
    check({tag, ".full"},  {15'd0, full},  {15'd0, f});
  endtask

  // Button low for 2 cycles then high for 2, changed on falling edges.
  task automatic press(input logic we, input logic [14:0] d);
    wren   = we;
    dataIn = d;
    button = 1'b0;
    repeat (2) @(negedge clock);
    button = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    button = 1'b1;
    resetN = 1'b0;
    repeat (2) @(negedge clock);
    resetN = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    resetN = 1'b1;
    button = 1'b1;
    wren   = 1'b0;
    dataIn = '0;

    // 1. Reset state
    @(negedge clock);
    resetN = 1'b0;
    repeat (2) @(negedge clock);
    check_flags("reset", 1'b1, 1'b0);
    check_digits("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    resetN = 1'b1;
    @(negedge clock);

    // 2. Single write with latency check: commit on 3rd rising edge after fall
    wren   = 1'b1;
    dataIn = 15'h1234;
    button = 1'b0;
    repeat (2) @(negedge clock);
    check_flags("lat_before", 1'b1, 1'b0);
    button = 1'b1;
    @(negedge clock);
    check_flags("lat_after", 1'b0, 1'b0);
    check_digits("w1234", 7'h79, 7'h24, 7'h30, 7'h19);
    @(negedge clock);

    // Reset during a pending press aborts it
    wren   = 1'b1;
    dataIn = 15'h0555;
    button = 1'b0;
    @(negedge clock);
    resetN = 1'b0;
    @(negedge clock);
    button = 1'b1;
    resetN = 1'b1;
    repeat (4) @(negedge clock);
    check_flags("abort", 1'b1, 1'b0);
    check_digits("abort", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    // 3. Fill with 8 writes of 7; 9th write (different data) ignored
    for (int i = 0; i < 8; i++) begin
      press(1'b1, 15'd7);
      check_flags($sformatf("fill%0d", i), 1'b0, (i == 7));
    end
    press(1'b1, 15'h7FFF);
    check_flags("fill_over", 1'b0, 1'b1);
    check_digits("fill_head", 7'h40, 7'h40, 7'h40, 7'h78);

    // 4. Drain with 8 reads; 9th read ignored
    for (int i = 0; i < 8; i++) begin
      press(1'b0, 15'd0);
      check_flags($sformatf("drain%0d", i), (i == 7), 1'b0);
    end
    check_digits("drain_blank", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
    press(1'b0, 15'd0);
    check_flags("drain_over", 1'b1, 1'b0);
    // Pointers must still agree: one write then one read returns to empty
    press(1'b1, 15'h2F0D);
    check_flags("post_w", 1'b0, 1'b0);
    check_digits("post_w", 7'h24, 7'h0E, 7'h40, 7'h21);
    press(1'b0, 15'd0);
    check_flags("post_r", 1'b1, 1'b0);

    // 5. Hold button low 10 cycles: exactly one write
    wren   = 1'b1;
    dataIn = 15'h0ABC;
    button = 1'b0;
    repeat (10) @(negedge clock);
    button = 1'b1;
    repeat (3) @(negedge clock);
    check_flags("hold", 1'b0, 1'b0);
    check_digits("hold", 7'h40, 7'h08, 7'h03, 7'h46);
    press(1'b0, 15'd0);
    check_flags("hold_r", 1'b1, 1'b0);

    // 6. Advance pointers to 14 with write/read pairs, then cross the wrap
    for (int i = 0; i < 4; i++) begin
      press(1'b1, 15'h0001);
      press(1'b0, 15'd0);
    end
    check_flags("prewrap", 1'b1, 1'b0);
    press(1'b1, 15'h000A);
    press(1'b1, 15'h000B);
    press(1'b0, 15'd0);
    check_digits("wrapB", 7'h40, 7'h40, 7'h40, 7'h03);
    press(1'b1, 15'h000C);
    press(1'b0, 15'd0);
    check_digits("wrapC", 7'h40, 7'h40, 7'h40, 7'h46);
    check_flags("wrapC", 1'b0, 1'b0);
    press(1'b0, 15'd0);
    check_flags("wrap_end", 1'b1, 1'b0);
    check_digits("wrap_end", 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    // Fill across the wrapped pointers to confirm full detection
    for (int i = 0; i < 8; i++) begin
      press(1'b1, 15'h4321 + 15'(i));
    end
    check_flags("wrap_full", 1'b0, 1'b1);
    check_digits("wrap_full", 7'h19, 7'h30, 7'h24, 7'h79);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
